timer_programmable: RTL and testbench

Runtime-programmable up-counting timer. It generalises the fixed-final-value modulus timer with parametrised width, a built-in clock prescaler, one-shot and periodic modes, start/stop control and a sticky expiry flag. It sits beside datapath blocks as a shared timebase and timeout generator. Its `done` pulse drives downstream strobes and FSM timeouts.

---
 rtl/timer_programmable_pkg.sv | 18 +
 rtl/timer_programmable_if.sv | 24 ++
 rtl/timer_programmable_prescaler.sv | 27 ++
 rtl/timer_programmable.sv | 84 ++++++++
 tb/tb_timer_programmable.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/timer_programmable_pkg.sv
// Shared definitions for the programmable timer: FSM states, mode constants
// and the prescaler width helper.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Prescaler counter width; a divide-by-1 still keeps a 1-bit register.
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/timer_programmable_if.sv
// Control/status bundle of the programmable timer.
interface timer_programmable_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             mode;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             busy;
  logic             expired;

  modport master (
    output start, stop, mode, enable, period,
    input  count, done, busy, expired
  );

  modport slave (
    input  start, stop, mode, enable, period,
    output count, done, busy, expired
  );
endinterface

// File: rtl/timer_programmable_prescaler.sv
// Clock prescaler: emits a one-cycle tick every DIV enabled cycles.
module prescaler_tick
  import timer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int            PW   = pre_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;

  assign tick = enable && (pre_q == LAST);

  // Disabled cycles hold the phase; clear realigns it to a fresh run.
  always_ff @(posedge clk) begin
    if (reset || clear)
      pre_q <= '0;
    else if (enable)
      pre_q <= tick ? '0 : pre_q + PW'(1);
  end
endmodule

// File: rtl/timer_programmable.sv
// Runtime-programmable up-counting timer with prescaler, one-shot/periodic
// modes, start/stop control and a sticky expiry flag.
module timer_programmable
  import timer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PRESCALE_DIV = 1
) (
  input logic              clk,
  input logic              reset,
  timer_programmable_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             tick;
  logic             start_go;

  // stop dominates a simultaneous start
  assign start_go = bus.start && !bus.stop;

  prescaler_tick #(.DIV(PRESCALE_DIV)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_go),
    .enable ((state_q == ST_RUN) && bus.enable),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    done_d    = 1'b0;
    if (bus.stop) begin
      if (state_q == ST_RUN) state_d = ST_IDLE;
    end else if (bus.start) begin
      state_d   = ST_RUN;
      count_d   = '0;
      period_d  = bus.period;
      mode_d    = bus.mode;
      expired_d = 1'b0;
    end else if (tick) begin
      if (count_q == period_q) begin
        count_d = '0;
        done_d  = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d   = ST_IDLE;
          expired_d = 1'b1;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      period_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.expired = expired_q;
endmodule

// File: tb/tb_timer_programmable.sv
// Directed bench: one timer with DIV=1 (ta) and one with DIV=3 (tb3).
module tb_timer_programmable;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ndone;

  always #5 clk = ~clk;

  timer_programmable_if #(.WIDTH(8)) ta ();
  timer_programmable_if #(.WIDTH(8)) tb3 ();

  timer_programmable #(.WIDTH(8), .PRESCALE_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(ta)
  );
  timer_programmable #(.WIDTH(8), .PRESCALE_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .bus(tb3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_a(input logic [7:0] per, input logic md);
    ta.period = per; ta.mode = md; ta.start = 1'b1;
    cyc(1);
    ta.start = 1'b0;
  endtask

  task automatic go_b(input logic [7:0] per, input logic md);
    tb3.period = per; tb3.mode = md; tb3.start = 1'b1;
    cyc(1);
    tb3.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ta.start = 0;  ta.stop = 0;  ta.mode = 0;  ta.enable = 1;  ta.period = 0;
    tb3.start = 0; tb3.stop = 0; tb3.mode = 0; tb3.enable = 1; tb3.period = 0;
    cyc(2);
    chk("rst_count", ta.count, 0);
    chk("rst_done", ta.done, 0);
    chk("rst_busy", ta.busy, 0);
    chk("rst_expired", ta.expired, 0);
    chk("rst_busy_b", tb3.busy, 0);
    reset = 1'b0;

    // 1: one-shot, period 3
    go_a(3, 0);
    chk("os_e0_count", ta.count, 0);
    chk("os_e0_busy", ta.busy, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      chk("os_count", ta.count, i);
      chk("os_nodone", ta.done, 0);
    end
    cyc(1);
    chk("os_done", ta.done, 1);
    chk("os_busy_fall", ta.busy, 0);
    chk("os_expired", ta.expired, 1);
    chk("os_count_wrap", ta.count, 0);
    cyc(1);
    chk("os_done_pulse", ta.done, 0);
    chk("os_expired_sticky", ta.expired, 1);

    // 2: periodic, period 4, DIV 3 -> done every 15 cycles
    go_b(4, 1);
    for (int p = 0; p < 3; p++) begin
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
        cyc(1);
        if (tb3.done) ndone++;
      end
      chk("per_done_at_15", tb3.done, 1);
      chk("per_one_pulse", ndone, 1);
      chk("per_busy", tb3.busy, 1);
      chk("per_expired", tb3.expired, 0);
    end
    tb3.stop = 1; cyc(1); tb3.stop = 0;
    chk("per_stop_busy", tb3.busy, 0);

    // prescaler phase freezes while enable is low (one-shot, period 1, DIV 3)
    go_b(1, 0);
    cyc(1);
    tb3.enable = 0; cyc(2); tb3.enable = 1;
    cyc(4);
    chk("pre_frz_count", tb3.count, 1);
    chk("pre_frz_nodone", tb3.done, 0);
    cyc(1);
    chk("pre_frz_done", tb3.done, 1);
    chk("pre_frz_expired", tb3.expired, 1);

    // 3: periodic, period 5, enable low 4 cycles
    go_a(5, 1);
    cyc(2);
    chk("en_count_pre", ta.count, 2);
    ta.enable = 0; cyc(4);
    chk("en_frozen", ta.count, 2);
    chk("en_busy", ta.busy, 1);
    ta.enable = 1;
    cyc(3);
    chk("en_count5", ta.count, 5);
    chk("en_nodone", ta.done, 0);
    cyc(1);
    chk("en_done_late", ta.done, 1);
    chk("en_periodic_busy", ta.busy, 1);
    ta.stop = 1; cyc(1); ta.stop = 0;

    // 4: stop mid-run, then start+stop together
    go_a(10, 0);
    cyc(6);
    chk("stop_count6", ta.count, 6);
    ta.stop = 1; cyc(1); ta.stop = 0;
    chk("stop_busy", ta.busy, 0);
    chk("stop_hold", ta.count, 6);
    chk("stop_expired", ta.expired, 0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (ta.done) ndone++;
    end
    chk("stop_nodone", ndone, 0);
    chk("stop_still_hold", ta.count, 6);
    ta.period = 2; ta.start = 1; ta.stop = 1; cyc(1); ta.start = 0; ta.stop = 0;
    chk("ss_idle", ta.busy, 0);
    chk("ss_count", ta.count, 6);

    // 5: restart at count 7 with a new period; mid-run period changes ignored
    go_a(9, 0);
    cyc(7);
    chk("rs_count7", ta.count, 7);
    go_a(2, 0);
    chk("rs_count0", ta.count, 0);
    chk("rs_busy", ta.busy, 1);
    ta.period = 9;
    cyc(2);
    chk("rs_count2", ta.count, 2);
    chk("rs_nodone", ta.done, 0);
    cyc(1);
    chk("rs_done", ta.done, 1);
    chk("rs_expired", ta.expired, 1);

    // 6a: period 0, periodic -> done every cycle
    go_a(0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("p0_done", ta.done, 1);
    end
    ta.stop = 1; cyc(1); ta.stop = 0;
    chk("p0_stop_done", ta.done, 0);
    chk("p0_stop_busy", ta.busy, 0);

    // 6b: full range, period 255
    go_a(255, 0);
    cyc(255);
    chk("full_count", ta.count, 255);
    chk("full_nodone", ta.done, 0);
    cyc(1);
    chk("full_done", ta.done, 1);
    chk("full_wrap", ta.count, 0);
    chk("full_expired", ta.expired, 1);

    // 6c: reset mid-run
    go_a(7, 1);
    cyc(3);
    chk("mr_count3", ta.count, 3);
    reset = 1; cyc(1); reset = 0;
    chk("mr_count", ta.count, 0);
    chk("mr_busy", ta.busy, 0);
    chk("mr_done", ta.done, 0);
    chk("mr_expired", ta.expired, 0);
    chk("mr_expired_b", tb3.expired, 0);
    cyc(2);
    chk("mr_stays_idle", ta.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
